// File: rtl/nco_phase_accumulator.sv
// nco_phase_accumulator: strobed NCO phase source with divider, phase-continuous FTW update, offset and clear
module nco_phase_accumulator #(
  parameter int ACC_WIDTH       = 48,
  parameter int INT_ANGLE_WIDTH = 32,
  parameter int DIV_WIDTH       = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              i_en,
  input  logic [DIV_WIDTH-1:0]              i_sample_div,
  input  logic [ACC_WIDTH-1:0]              i_ftw,
  input  logic                              i_ftw_wr,
  input  logic                              i_update_at_wrap,
  input  logic [INT_ANGLE_WIDTH-1:0]        i_phase_offset,
  input  logic                              i_phase_clr,
  output logic                              o_valid,
  output logic signed [INT_ANGLE_WIDTH-1:0] o_target_angle,
  output logic                              o_wrap,
  output logic                              o_ftw_pending
);
  logic [DIV_WIDTH-1:0]       cnt;
  logic [ACC_WIDTH-1:0]       acc, ftw_active, ftw_pend, ftw_used;
  logic [INT_ANGLE_WIDTH-1:0] ph1;
  logic                       carry_q, mode, tick, apply, v1, w1;
  always_comb begin
    tick     = i_en && cnt == i_sample_div && !i_phase_clr;
    apply    = tick && o_ftw_pending && (!mode || carry_q);
    ftw_used = apply ? ftw_pend : ftw_active;
  end
  always_ff @(posedge clk)
    if (rst) begin
      cnt            <= '0;
      acc            <= '0;
      carry_q        <= 1'b0;
      ftw_active     <= '0;
      ftw_pend       <= '0;
      mode           <= 1'b0;
      ph1            <= '0;
      w1             <= 1'b0;
      v1             <= 1'b0;
      o_valid        <= 1'b0;
      o_target_angle <= '0;
      o_wrap         <= 1'b0;
      o_ftw_pending  <= 1'b0;
    end else begin
      cnt <= (tick || !i_en || i_phase_clr) ? '0 : cnt + 1'b1;
      v1  <= tick;
      if (tick) begin
        ph1            <= acc[ACC_WIDTH-1 -: INT_ANGLE_WIDTH];
        w1             <= carry_q;
        {carry_q, acc} <= {1'b0, acc} + {1'b0, ftw_used};
      end else if (i_phase_clr) begin
        acc     <= '0;
        carry_q <= 1'b0;
      end
      if (apply)
        ftw_active <= ftw_pend;
      if (i_ftw_wr) begin
        ftw_pend      <= i_ftw;
        mode          <= i_update_at_wrap;
        o_ftw_pending <= 1'b1;
      end else if (apply)
        o_ftw_pending <= 1'b0;
      o_valid <= v1 && !i_phase_clr;
      if (v1 && !i_phase_clr) begin
        o_target_angle <= ph1 + i_phase_offset;
        o_wrap         <= w1;
      end
    end
endmodule

// File: tb/tb_nco_phase_accumulator.sv
// tb_nco_phase_accumulator: directed and randomized checks of the NCO against a phase-total reference model
module tb_nco_phase_accumulator;
  localparam int AW = 48, IW = 32, DW = 16, HN = 1024;
  typedef struct {int due; logic [IW-1:0] ph; logic w;} smp_t;
  logic clk = 0, rst = 1, en = 0, ftw_wr = 0, upd = 0, clr = 0;
  logic [DW-1:0] div = '0;
  logic [AW-1:0] ftw = '0;
  logic [IW-1:0] off = '0, o_angle;
  logic o_valid, o_wrap, o_ftw_pending;
  int tests = 0, fails = 0, cyc = 0, n;
  smp_t q[$], s;
  logic [IW-1:0] off_hist [HN];
  logic [63:0] m_total, nt;
  logic [AW-1:0] m_active, m_pend, step;
  logic [DW-1:0] m_cnt;
  logic [IW-1:0] m_ang;
  logic m_carry, m_mode, m_pending, m_w, t, ap, ev;
  always #5 clk = ~clk;
  nco_phase_accumulator dut (
    .clk(clk), .rst(rst), .i_en(en), .i_sample_div(div), .i_ftw(ftw), .i_ftw_wr(ftw_wr),
    .i_update_at_wrap(upd), .i_phase_offset(off), .i_phase_clr(clr), .o_valid(o_valid),
    .o_target_angle(o_angle), .o_wrap(o_wrap), .o_ftw_pending(o_ftw_pending)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask
  always @(posedge clk) begin
    off_hist[cyc % HN] = off;
    if (rst) begin
      q.delete();
      {m_total, m_carry, m_active, m_pend, m_mode, m_pending, m_cnt, m_ang, m_w} = '0;
    end else begin
      t  = en && m_cnt == div && !clr;
      ap = t && m_pending && (!m_mode || m_carry);
      if (clr)
        while (q.size() > 0 && q[$].due > cyc) void'(q.pop_back());
      if (t) begin
        step = ap ? m_pend : m_active;
        q.push_back('{cyc + 2, m_total[AW-1:AW-IW], m_carry});
        nt = m_total + 64'(step);
        m_carry = nt[63:AW] != m_total[63:AW];
        m_total = nt;
      end else if (clr) begin
        m_total = '0;
        m_carry = 1'b0;
      end
      if (ap) m_active = m_pend;
      if (ftw_wr) begin
        m_pend = ftw;
        m_mode = upd;
        m_pending = 1'b1;
      end else if (ap) m_pending = 1'b0;
      m_cnt = (t || !en || clr) ? '0 : m_cnt + 1'b1;
    end
    cyc++;
  end
  always @(negedge clk)
    if (cyc > 0) begin
      ev = 1'b0;
      if (q.size() > 0 && q[0].due == cyc) begin
        s = q.pop_front();
        ev = 1'b1;
        m_ang = s.ph + off_hist[(cyc - 1) % HN];
        m_w = s.w;
      end
      check("mon_valid", 64'(o_valid), 64'(ev));
      check("mon_angle", 64'(o_angle), 64'(m_ang));
      check("mon_wrap", 64'(o_wrap), 64'(m_w));
      check("mon_ftw_pending", 64'(o_ftw_pending), 64'(m_pending));
    end
  task automatic do_reset();
    rst = 1; en = 0; ftw_wr = 0; clr = 0;
    repeat (2) @(negedge clk);
    check("rst_valid", 64'(o_valid), 0);
    check("rst_angle", 64'(o_angle), 0);
    check("rst_wrap", 64'(o_wrap), 0);
    check("rst_pending", 64'(o_ftw_pending), 0);
    rst = 0;
  endtask
  task automatic wr_ftw(input logic [AW-1:0] v, input logic m);
    ftw = v; upd = m; ftw_wr = 1;
    @(negedge clk);
    ftw_wr = 0;
  endtask
  task automatic expect_strobe(input string tag, input logic [IW-1:0] a, input logic w);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!o_valid && k < 40);
    check({tag, "_seen"}, 64'(o_valid), 1);
    check({tag, "_angle"}, 64'(o_angle), 64'(a));
    check({tag, "_wrap"}, 64'(o_wrap), 64'(w));
  endtask
  task automatic count_to_strobe(output int k);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!o_valid && k < 20);
  endtask
  initial begin
    do_reset();
    div = 0; off = 0;
    wr_ftw(48'h4000_0000_0000, 0);
    en = 1;
    expect_strobe("t1_s0", 32'h0000_0000, 0);
    expect_strobe("t1_s1", 32'h4000_0000, 0);
    expect_strobe("t1_s2", 32'h8000_0000, 0);
    expect_strobe("t1_s3", 32'hC000_0000, 0);
    expect_strobe("t1_s4", 32'h0000_0000, 1);
    en = 0;
    repeat (4) @(negedge clk);
    div = 3; en = 1;
    count_to_strobe(n);
    check("t2_first_latency", 64'(n), 5);
    count_to_strobe(n);
    check("t2_period", 64'(n), 4);
    en = 0;
    repeat (2) @(negedge clk);
    repeat (5) begin
      @(negedge clk);
      check("t2_drained", 64'(o_valid), 0);
    end
    do_reset();
    div = 0; off = 32'h4000_0000;
    wr_ftw(48'h4000_0000_0000, 0);
    en = 1;
    expect_strobe("t3_s0", 32'h4000_0000, 0);
    expect_strobe("t3_s1", 32'h8000_0000, 0);
    expect_strobe("t3_s2", 32'hC000_0000, 0);
    expect_strobe("t3_s3", 32'h0000_0000, 0);
    do_reset();
    div = 3; off = 0;
    wr_ftw(48'h4000_0000_0000, 0);
    en = 1;
    expect_strobe("t4_s0", 32'h0000_0000, 0);
    expect_strobe("t4_s1", 32'h4000_0000, 0);
    wr_ftw(48'h2000_0000_0000, 1);
    check("t4_pending", 64'(o_ftw_pending), 1);
    expect_strobe("t4_s2", 32'h8000_0000, 0);
    check("t4_still_pending", 64'(o_ftw_pending), 1);
    expect_strobe("t4_s3", 32'hC000_0000, 0);
    expect_strobe("t4_s4", 32'h0000_0000, 1);
    check("t4_pending_cleared", 64'(o_ftw_pending), 0);
    expect_strobe("t4_s5", 32'h2000_0000, 0);
    expect_strobe("t4_s6", 32'h4000_0000, 0);
    wr_ftw(48'h1000_0000_0000, 1);
    @(negedge clk);
    clr = 1;
    @(negedge clk);
    clr = 0;
    expect_strobe("t5_s0", 32'h0000_0000, 0);
    expect_strobe("t5_s1", 32'h2000_0000, 0);
    check("t5_pending_kept", 64'(o_ftw_pending), 1);
    div = 0;
    repeat (3) @(negedge clk);
    rst = 1;
    @(negedge clk);
    check("t6_valid", 64'(o_valid), 0);
    check("t6_angle", 64'(o_angle), 0);
    check("t6_wrap", 64'(o_wrap), 0);
    check("t6_pending", 64'(o_ftw_pending), 0);
    rst = 0;
    expect_strobe("t6_s0", 32'h0000_0000, 0);
    expect_strobe("t6_s1", 32'h0000_0000, 0);
    en = 1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rst = $urandom_range(299) == 0;
      ftw_wr = $urandom_range(7) == 0;
      if (ftw_wr) begin
        ftw = AW'({$urandom(), $urandom()});
        upd = 1'($urandom_range(1));
      end
      clr = $urandom_range(59) == 0;
      if ($urandom_range(39) == 0) en = !en;
      if ($urandom_range(49) == 0) div = DW'($urandom_range(3));
      if ($urandom_range(19) == 0) off = $urandom();
    end
    @(negedge clk);
    rst = 0; ftw_wr = 0; clr = 0;
    repeat (10) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
